probe_capture_router: RTL and testbench
=======================================

// Module: probe_capture_router
// PURPOSE
// Parametrised successor to the fixed top-level test muxes: routes one of NUM_PROBES internal buses
// (coder sinI/sinQ, decoder I/Q, CORDIC dir, CDR data/flag, ...) to a PROBE_W pin group.
// Adds a serially loaded configuration, decimated sampling, and a trigger-qualified capture buffer read out over a pin.
// Sits in the chip top beside the datapath. Probe inputs come from the blocks; config/arm/trigger/read come from pins.
// PARAMETERS
// NUM_PROBES  16  number of observable buses (>=2)
// PROBE_W     4   width of each probe bus and of outData
// DEPTH       16  capture buffer entries, power of 2, >=4
// SEL_W       $clog2(NUM_PROBES)  probe select width (derived, do not override)
// PORTS
// inClock        in   1                   single clock, all logic rising-edge
// inReset        in   1                   asynchronous, active-low reset
// inProbeBus     in   NUM_PROBES*PROBE_W  probe k = inProbeBus[k*PROBE_W +: PROBE_W]
// inCfgShift     in   1                   shift enable for config register
// inCfgData      in   1                   serial config bit, MSB first
// inCfgUpdate    in   1                   copy shift register to active config
// inArm          in   1                   start capture sequence (pulse)
// inTrigger      in   1                   capture trigger (level, sampled)
// inReadEnable   in   1                   pop one captured sample
// outLive        out  PROBE_W             registered selected probe (bypass view)
// outData        out  PROBE_W             popped sample
// outValid       out  1                   outData valid, 1-cycle pulse
// outEmpty       out  1                   no unread samples
// outDone        out  1                   FSM in DONE
// outArmed       out  1                   FSM in ARMED or CAPTURE
// BEHAVIOUR
// - Reset: all state cleared, config = 0, FSM IDLE, outLive/outData = 0, outValid/outDone/outArmed = 0, outEmpty = 1.
// - Config word CFG_W = SEL_W+6: {sel[SEL_W-1:0], mode[1:0], decim[3:0]}. Shift: sr <= {sr[CFG_W-2:0], inCfgData}.
// - inCfgUpdate applies only in IDLE or DONE (DONE -> IDLE, buffer cleared); ignored in ARMED/CAPTURE. Shift+update same cycle: update takes pre-shift value.
// - sel >= NUM_PROBES selects probe 0. outLive = selected probe delayed 1 cycle, always active in every mode.
// - Sample strobe: free-running counter, strobe when cnt==decim, then cnt<=0 (every decim+1 cycles); counter cleared on arm.
// - mode 00 bypass: inArm ignored, FSM stays IDLE. mode 11 reserved = bypass.
// - mode 01 one-shot: IDLE -inArm-> ARMED -inTrigger-> CAPTURE. Write DEPTH strobed samples, first write on the trigger cycle if strobe. Then -> DONE.
// - mode 10 pre-trigger ring: ARMED writes every strobe, wrapping. On inTrigger -> CAPTURE, then DEPTH/2 further writes -> DONE.
//   Ring wraps freely in ARMED. The valid count saturates at DEPTH. Readout starts at the oldest entry (wr_ptr if wrapped, else 0).
// - Trigger and strobe in the same cycle as arm: the trigger is ignored. Only the next cycle's trigger counts.
// - Readout only in DONE. inReadEnable && !outEmpty -> outData = entry, outValid = 1 on the next cycle. Read while empty or not DONE: no effect, outValid = 0.
// - outEmpty = 1 whenever unread count == 0 (includes IDLE/ARMED/CAPTURE). Pointers wrap modulo DEPTH.
// - inArm in DONE re-arms: buffer cleared, -> ARMED. inArm in ARMED/CAPTURE is ignored.
// - Async reset mid-capture aborts immediately to the reset state. No partial data survives.
// TESTING
// - Reset: hold inReset=0 with probes toggling -> all outputs 0, outEmpty=1. Release -> outLive follows probe 0 one cycle late.
// - Shift sel=5, mode=00, decim=0, pulse update -> outLive = probe5 one cycle late. Pulse inArm -> outArmed stays 0.
// - mode=01, decim=0, probe5 = cycle count: arm, trigger at value 0x3 -> DONE after 16 writes. Read 16 samples 0x3..0x2 (wrapping 4-bit). 17th read: no outValid.
// - mode=01, decim=2: capture -> consecutive read samples differ by 3. outDone is asserted 48 cycles after trigger (+/-2).
// - mode=10, decim=0: arm, 40 cycles, trigger -> 8 post-trigger samples. Readout gives 8 pre- and 8 post-trigger values in order.
// - Apply inCfgUpdate and inArm in CAPTURE -> both ignored. Assert reset mid-CAPTURE -> state IDLE, outEmpty=1.

Source files
------------

// File: rtl/probe_capture_router.sv
// Routes one of NUM_PROBES internal buses to a pin group. It can also capture decimated
// samples into a one-shot or pre-trigger ring buffer, which is then read out over pins.
module probe_capture_router #(
    parameter int NUM_PROBES = 16,
    parameter int PROBE_W    = 4,
    parameter int DEPTH      = 16,
    localparam int SEL_W     = $clog2(NUM_PROBES)
) (
    input  logic                          inClock,
    input  logic                          inReset,
    input  logic [NUM_PROBES*PROBE_W-1:0] inProbeBus,
    input  logic                          inCfgShift,
    input  logic                          inCfgData,
    input  logic                          inCfgUpdate,
    input  logic                          inArm,
    input  logic                          inTrigger,
    input  logic                          inReadEnable,
    output logic [PROBE_W-1:0]            outLive,
    output logic [PROBE_W-1:0]            outData,
    output logic                          outValid,
    output logic                          outEmpty,
    output logic                          outDone,
    output logic                          outArmed
);

    localparam int CFG_W = SEL_W + 6;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [1:0] MODE_ONESHOT = 2'b01;
    localparam logic [1:0] MODE_RING    = 2'b10;
    localparam logic [PTR_W:0] FULL_COUNT   = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONESHOT_LAST = (PTR_W+1)'(DEPTH - 1);
    localparam logic [PTR_W:0] RING_LAST    = (PTR_W+1)'(DEPTH/2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CFG_W-1:0]     r_cfg_sr;
    logic [CFG_W-1:0]     r_cfg;
    logic [3:0]           r_cnt;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W:0]       r_count;
    logic [PTR_W:0]       r_post_cnt;
    logic [PROBE_W-1:0]   r_live;
    logic [PROBE_W-1:0]   r_data;
    logic                 r_valid;
    logic [PROBE_W-1:0]   r_mem [DEPTH];

    logic [PROBE_W-1:0]   w_probes [NUM_PROBES];
    logic [SEL_W-1:0]     w_sel;
    logic [1:0]           w_mode;
    logic [3:0]           w_decim;
    logic [PROBE_W-1:0]   w_probe;
    logic                 w_idle_or_done;
    logic                 w_cfg_apply;
    logic                 w_arm_go;
    logic                 w_strobe;
    logic                 w_post_wr;
    logic                 w_wr;
    logic [PTR_W:0]       w_post_last;
    logic                 w_capture_end;
    logic                 w_rd;
    logic                 w_clear;

    for (genvar gi = 0; gi < NUM_PROBES; gi++) begin : g_probe
        assign w_probes[gi] = inProbeBus[gi*PROBE_W +: PROBE_W];
    end

    assign w_sel   = r_cfg[CFG_W-1 -: SEL_W];
    assign w_mode  = r_cfg[5:4];
    assign w_decim = r_cfg[3:0];
    assign w_probe = (32'(w_sel) < NUM_PROBES) ? w_probes[w_sel] : w_probes[0];

    // A config update takes priority over an arm arriving in the same cycle.
    assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_cfg_apply    = inCfgUpdate && w_idle_or_done;
    assign w_arm_go       = inArm && w_idle_or_done && !w_cfg_apply &&
                            ((w_mode == MODE_ONESHOT) || (w_mode == MODE_RING));
    assign w_clear        = w_arm_go || w_cfg_apply;

    assign w_strobe      = (r_cnt == w_decim);
    assign w_post_wr     = w_strobe && (((r_state == S_ARMED) && inTrigger) || (r_state == S_CAPTURE));
    assign w_wr          = w_post_wr || (w_strobe && (r_state == S_ARMED) && (w_mode == MODE_RING));
    assign w_post_last   = (w_mode == MODE_ONESHOT) ? ONESHOT_LAST : RING_LAST;
    assign w_capture_end = w_post_wr && (r_post_cnt == w_post_last);
    assign w_rd          = inReadEnable && (r_state == S_DONE) && (r_count != '0);

    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_arm_go) w_state_next = S_ARMED;
            S_ARMED:   if (inTrigger) w_state_next = S_CAPTURE;
            S_CAPTURE: if (w_capture_end) w_state_next = S_DONE;
            S_DONE: begin
                if (w_cfg_apply) begin
                    w_state_next = S_IDLE;
                end else if (w_arm_go) begin
                    w_state_next = S_ARMED;
                end
            end
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        outDone  = (r_state == S_DONE);
        outArmed = (r_state == S_ARMED) || (r_state == S_CAPTURE);
        outEmpty = (r_state != S_DONE) || (r_count == '0);
    end

    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            r_cfg_sr   <= '0;
            r_cfg      <= '0;
            r_cnt      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_post_cnt <= '0;
            r_live     <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
        end else begin
            if (inCfgShift) r_cfg_sr <= {r_cfg_sr[CFG_W-2:0], inCfgData};
            if (w_cfg_apply) r_cfg <= r_cfg_sr;
            r_cnt   <= (w_arm_go || w_strobe) ? 4'd0 : r_cnt + 4'd1;
            r_live  <= w_probe;
            r_valid <= w_rd;
            if (w_rd) r_data <= r_mem[r_rd_ptr];
            // r_rd_ptr always tracks the oldest entry; a write into a full ring pushes it along.
            if (w_clear) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_post_cnt <= '0;
            end else if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_count == FULL_COUNT) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
                if (w_post_wr) r_post_cnt <= r_post_cnt + 1'b1;
            end else if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count  <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge inClock) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_probe;
    end

    assign outLive  = r_live;
    assign outData  = r_data;
    assign outValid = r_valid;

endmodule

// File: tb/tb_probe_capture_router.sv
// Directed bench for probe_capture_router: bypass routing, one-shot and ring capture, readout.
module tb_probe_capture_router;

    localparam int NP = 16;
    localparam int PW = 4;
    localparam int DP = 16;
    localparam int CW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [NP*PW-1:0] bus;
    logic             cfg_shift, cfg_data, cfg_upd, arm, trig, rd_en;
    logic [PW-1:0]    live, data;
    logic             valid, empty, done, armed;
    logic [PW-1:0]    probe [NP];
    bit               cnt_en = 1'b0;
    int               checks = 0;
    int               errors = 0;

    always_comb begin
        bus = '0;
        for (int k = 0; k < NP; k++) bus[k*PW +: PW] = probe[k];
    end

    probe_capture_router #(.NUM_PROBES(NP), .PROBE_W(PW), .DEPTH(DP)) dut (
        .inClock(clk), .inReset(rst_n), .inProbeBus(bus),
        .inCfgShift(cfg_shift), .inCfgData(cfg_data), .inCfgUpdate(cfg_upd),
        .inArm(arm), .inTrigger(trig), .inReadEnable(rd_en),
        .outLive(live), .outData(data), .outValid(valid),
        .outEmpty(empty), .outDone(done), .outArmed(armed)
    );

    // Inputs change 1 ns after each rising edge; probe 5 optionally counts once per cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (cnt_en) probe[5] = probe[5] + 4'd1;
    endtask

    task automatic shift_cfg(input logic [3:0] sel, input logic [1:0] mode, input logic [3:0] decim);
        logic [CW-1:0] w;
        w = {sel, mode, decim};
        for (int i = CW - 1; i >= 0; i--) begin
            cfg_shift = 1'b1;
            cfg_data  = w[i];
            tick();
        end
        cfg_shift = 1'b0;
        cfg_data  = 1'b0;
    endtask

    task automatic load_cfg(input logic [3:0] sel, input logic [1:0] mode, input logic [3:0] decim);
        shift_cfg(sel, mode, decim);
        cfg_upd = 1'b1;
        tick();
        cfg_upd = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < NP; k++) probe[k] = 4'($urandom_range(0, 15));
            tick();
            checks++;
            if ({live, data, valid, done, armed, empty} !== {4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL reset_outputs: got live=%h data=%h valid=%b done=%b armed=%b empty=%b, want 0 0 0 0 0 1",
                         live, data, valid, done, armed, empty);
            end
        end
        rst_n = 1'b1;
        probe[0] = 4'h9;
        tick();
        checks++;
        if (live !== 4'h9) begin errors++; $display("FAIL live_probe0: got %h want 9", live); end
        probe[0] = 4'h6;
        #1;
        checks++;
        if (live !== 4'h9) begin errors++; $display("FAIL live_delay: got %h want 9", live); end
        tick();
        checks++;
        if (live !== 4'h6) begin errors++; $display("FAIL live_probe0_b: got %h want 6", live); end
        $display("reset: done");
    endtask

    task automatic test_bypass();
        load_cfg(4'd5, 2'b00, 4'd0);
        probe[5] = 4'hB;
        probe[0] = 4'h1;
        tick();
        checks++;
        if (live !== 4'hB) begin errors++; $display("FAIL bypass_live_sel5: got %h want b", live); end
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        checks++;
        if (armed !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL bypass_arm_ignored: got armed=%b done=%b want 0 0", armed, done);
        end
        $display("bypass: live=%h armed=%b", live, armed);
    endtask

    task automatic test_oneshot();
        int n;
        logic [3:0] exp;
        load_cfg(4'd5, 2'b01, 4'd0);
        probe[5] = 4'h0;
        cnt_en = 1'b1;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        checks++;
        if (armed !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_armed: got armed=%b done=%b want 1 0", armed, done);
        end
        n = 0;
        while (probe[5] != 4'h3 && n < 20) begin tick(); n++; end
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (14) tick();
        checks++;
        if (done !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_early_done: got done=%b empty=%b want 0 1", done, empty);
        end
        tick();
        checks++;
        if (done !== 1'b1 || empty !== 1'b0 || armed !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_done: got done=%b empty=%b armed=%b want 1 0 0", done, empty, armed);
        end
        rd_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            exp = 4'(3 + k);
            $display("oneshot read %0d: data=%h valid=%b", k, data, valid);
            checks++;
            if (valid !== 1'b1 || data !== exp) begin
                errors++;
                $display("FAIL oneshot_read%0d: got data=%h valid=%b want data=%h valid=1", k, data, valid, exp);
            end
        end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL oneshot_empty: got %b want 1", empty); end
        tick();
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL oneshot_read17: got valid=%b want 0", valid); end
        rd_en = 1'b0;
    endtask

    task automatic test_decim();
        int n;
        logic [3:0] p;
        logic [3:0] exp;
        load_cfg(4'd5, 2'b01, 4'd2);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        trig = 1'b1;
        p = probe[5];
        tick();
        trig = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 100) begin tick(); n++; end
        $display("decim: done %0d cycles after trigger", n);
        checks++;
        if (n < 46 || n > 50) begin
            errors++;
            $display("FAIL decim_done_latency: got %0d cycles want 46..50", n);
        end
        rd_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            exp = 4'(p + 4'd2 + 4'(3 * k));
            $display("decim read %0d: data=%h valid=%b", k, data, valid);
            checks++;
            if (valid !== 1'b1 || data !== exp) begin
                errors++;
                $display("FAIL decim_read%0d: got data=%h valid=%b want data=%h valid=1", k, data, valid, exp);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_ring();
        logic [3:0] q;
        logic [3:0] exp;
        load_cfg(4'd5, 2'b10, 4'd0);
        arm = 1'b1;
        trig = 1'b1;
        tick();
        arm = 1'b0;
        trig = 1'b0;
        checks++;
        if (armed !== 1'b1) begin errors++; $display("FAIL ring_armed: got %b want 1", armed); end
        repeat (40) tick();
        q = probe[5];
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (6) tick();
        checks++;
        if (done !== 1'b0 || armed !== 1'b1) begin
            errors++;
            $display("FAIL ring_early_done: got done=%b armed=%b want 0 1", done, armed);
        end
        tick();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL ring_done: got %b want 1", done); end
        rd_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            exp = 4'(q - 4'd8 + 4'(k));
            $display("ring read %0d: data=%h valid=%b", k, data, valid);
            checks++;
            if (valid !== 1'b1 || data !== exp) begin
                errors++;
                $display("FAIL ring_read%0d: got data=%h valid=%b want data=%h valid=1", k, data, valid, exp);
            end
        end
        rd_en = 1'b0;
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL ring_empty: got %b want 1", empty); end
    endtask

    task automatic test_capture_ignore();
        load_cfg(4'd5, 2'b01, 4'd0);
        probe[3] = 4'hA;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        shift_cfg(4'd3, 2'b00, 4'd0);
        cfg_upd = 1'b1;
        tick();
        cfg_upd = 1'b0;
        checks++;
        if (armed !== 1'b1 || done !== 1'b0 || live !== 4'(probe[5] - 4'd1)) begin
            errors++;
            $display("FAIL capture_update_ignored: got armed=%b done=%b live=%h want 1 0 %h",
                     armed, done, live, 4'(probe[5] - 4'd1));
        end
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (2) tick();
        checks++;
        if (done !== 1'b0 || armed !== 1'b1) begin
            errors++;
            $display("FAIL capture_arm_ignored: got done=%b armed=%b want 0 1", done, armed);
        end
        tick();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL capture_done: got %b want 1", done); end
        $display("capture_ignore: done=%b", done);

        arm = 1'b1;
        tick();
        arm = 1'b0;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (2) tick();
        checks++;
        if (armed !== 1'b1) begin errors++; $display("FAIL abort_pre: got armed=%b want 1", armed); end
        #2;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({armed, done, empty, live, valid} !== {1'b0, 1'b0, 1'b1, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL abort_reset: got armed=%b done=%b empty=%b live=%h valid=%b want 0 0 1 0 0",
                     armed, done, empty, live, valid);
        end
        tick();
        rst_n = 1'b1;
        probe[0] = 4'hC;
        tick();
        checks++;
        if (live !== 4'hC) begin errors++; $display("FAIL abort_cfg_cleared: got live=%h want c", live); end
        arm = 1'b1;
        tick();
        arm = 1'b0;
        checks++;
        if (armed !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL abort_bypass_arm: got armed=%b empty=%b want 0 1", armed, empty);
        end
        $display("abort: live=%h armed=%b", live, armed);
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_shift = 1'b0;
        cfg_data  = 1'b0;
        cfg_upd   = 1'b0;
        arm       = 1'b0;
        trig      = 1'b0;
        rd_en     = 1'b0;
        for (int k = 0; k < NP; k++) probe[k] = 4'h0;
        test_reset();
        test_bypass();
        test_oneshot();
        test_decim();
        test_ring();
        test_capture_ignore();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
